fixed_mul_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point multiplier for the Math library.
- Successor to the 1-cycle multiplier: configurable depth, valid/ready backpressure, per-transaction rounding and saturation, overflow flag, and an opaque tag carried alongside the data.
- Sits between ray/shading datapath producers and consumers that may stall.

---
 rtl/fixed_point_pkg.sv | 31 +++
 rtl/fixed_round_sat.sv | 57 +++++
 rtl/fixed_mul_pipe.sv | 160 ++++++++++++++++
 tb/tb_fixed_mul_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the Math library: default Q format,
// range limits and the mode/payload types carried through arithmetic pipelines.
package fixed_point_pkg;

  localparam int FX_WIDTH  = 16;
  localparam int FX_Q_BITS = 8;
  localparam int FX_TAG_W  = 4;

  // Range limits of a w-bit two's complement value (valid for w <= 64).
  function automatic logic signed [63:0] fx_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fx_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  typedef struct packed {
    logic round_en;
    logic sat_en;
  } fx_mode_t;

  // Default-width stage payload; parameterised blocks declare a local
  // equivalent with the same field layout.
  typedef struct packed {
    logic signed [2*FX_WIDTH-1:0] prod;
    fx_mode_t                     mode;
    logic [FX_TAG_W-1:0]          tag;
  } fx_stage_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational post-processing of a full-width signed product: optional
// round-half-up, arithmetic shift by Q_BITS, overflow detect and clamp/wrap.
module fixed_round_sat
  import fixed_point_pkg::*;
#(
  parameter int WIDTH  = FX_WIDTH,
  parameter int Q_BITS = FX_Q_BITS
) (
  input  logic signed [2*WIDTH-1:0] prod,
  input  fx_mode_t                  mode,
  output logic signed [WIDTH-1:0]   result,
  output logic                      overflow
);

  // One guard bit so the rounding increment can never wrap.
  localparam int EW = 2*WIDTH + 1;

  localparam logic signed [EW-1:0] HALF =
    (Q_BITS > 0) ? (EW'(1) <<< ((Q_BITS > 0) ? Q_BITS - 1 : 0)) : '0;

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(fx_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(fx_min(WIDTH));

  function automatic logic signed [EW-1:0] round_half_up(
    input logic signed [EW-1:0] p,
    input logic                 rnd
  );
    return rnd ? p + HALF : p;
  endfunction

  // In range iff every bit from the result sign bit upward is a sign copy.
  function automatic logic range_ovf(input logic signed [EW-1:0] r);
    logic [EW-WIDTH:0] top;
    top = r[EW-1:WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [EW-1:0] r,
    input logic                 ovf,
    input logic                 sat
  );
    if (ovf && sat) return r[EW-1] ? MIN_V : MAX_V;
    return r[WIDTH-1:0];
  endfunction

  logic signed [EW-1:0] p_rnd;
  logic signed [EW-1:0] r_sh;

  always_comb begin
    p_rnd    = round_half_up(EW'(prod), mode.round_en);
    r_sh     = p_rnd >>> Q_BITS;
    overflow = range_ovf(r_sh);
    result   = saturate(r_sh, overflow, mode.sat_en);
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready backpressure,
// per-beat round/saturate mode, overflow flag and a passthrough tag.
module fixed_mul_pipe
  import fixed_point_pkg::*;
#(
  parameter int WIDTH  = FX_WIDTH,
  parameter int Q_BITS = FX_Q_BITS,
  parameter int STAGES = 3,
  parameter int TAG_W  = FX_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    round_en,
  input  logic                    sat_en,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic [TAG_W-1:0]        tag_out
);

  localparam int PW = 2*WIDTH;

  typedef struct packed {
    logic signed [PW-1:0] prod;
    fx_mode_t             mode;
    logic [TAG_W-1:0]     tag;
  } stage_t;

  function automatic logic signed [PW-1:0] mul_full(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    return PW'(x) * PW'(y);
  endfunction

  // Whole pipeline advances together; only a held output beat stalls it.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  fx_mode_t mode_in;
  assign mode_in = '{round_en: round_en, sat_en: sat_en};

  // Beat presented to the round/saturate logic in front of the output register.
  logic signed [PW-1:0] fin_prod;
  fx_mode_t             fin_mode;
  logic [TAG_W-1:0]     fin_tag;
  logic                 fin_vld;

  generate
    if (STAGES == 1) begin : g_one
      assign fin_prod = mul_full(a, b);
      assign fin_mode = mode_in;
      assign fin_tag  = tag_in;
      assign fin_vld  = in_valid;
    end else begin : g_multi
      // ---- stage 1: operand, mode and tag capture ----
      logic signed [WIDTH-1:0] a_p1;
      logic signed [WIDTH-1:0] b_p1;
      fx_mode_t                mode_p1;
      logic [TAG_W-1:0]        tag_p1;
      logic                    vld_p1;

      always_ff @(posedge clk) begin
        if (rst)     vld_p1 <= 1'b0;
        else if (en) vld_p1 <= in_valid;
      end

      always_ff @(posedge clk) begin
        if (en) begin
          a_p1    <= a;
          b_p1    <= b;
          mode_p1 <= mode_in;
          tag_p1  <= tag_in;
        end
      end

      if (STAGES == 2) begin : g_two
        assign fin_prod = mul_full(a_p1, b_p1);
        assign fin_mode = mode_p1;
        assign fin_tag  = tag_p1;
        assign fin_vld  = vld_p1;
      end else begin : g_deep
        // ---- stages 2..STAGES-1: product register then delay line ----
        localparam int M = STAGES - 2;

        stage_t         head_p1;
        stage_t         beat_pm [M];
        logic [M-1:0]   vld_pm;

        always_comb begin
          head_p1      = '0;
          head_p1.prod = mul_full(a_p1, b_p1);
          head_p1.mode = mode_p1;
          head_p1.tag  = tag_p1;
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            vld_pm <= '0;
          end else if (en) begin
            vld_pm[0] <= vld_p1;
            for (int i = 1; i < M; i++) vld_pm[i] <= vld_pm[i-1];
          end
        end

        always_ff @(posedge clk) begin
          if (en) begin
            beat_pm[0] <= head_p1;
            for (int i = 1; i < M; i++) beat_pm[i] <= beat_pm[i-1];
          end
        end

        assign fin_prod = beat_pm[M-1].prod;
        assign fin_mode = beat_pm[M-1].mode;
        assign fin_tag  = beat_pm[M-1].tag;
        assign fin_vld  = vld_pm[M-1];
      end
    end
  endgenerate

  logic signed [WIDTH-1:0] rs_result;
  logic                    rs_ovf;

  fixed_round_sat #(
    .WIDTH  (WIDTH),
    .Q_BITS (Q_BITS)
  ) u_round_sat (
    .prod     (fin_prod),
    .mode     (fin_mode),
    .result   (rs_result),
    .overflow (rs_ovf)
  );

  // ---- stage STAGES: output register ----
  // Data loads only with a valid beat so idle outputs stay at their last
  // delivered value, or zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      tag_out   <= '0;
    end else if (en) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        result   <= rs_result;
        overflow <= rs_ovf;
        tag_out  <= fin_tag;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Scoreboard bench for fixed_mul_pipe: directed arithmetic, backpressure and
// reset steps on a 16/Q8/3-stage instance, plus Q0 sweeps at depths 1 and 5.
module tb_fixed_mul_pipe;

  localparam int W  = 16;
  localparam int Q  = 8;
  localparam int ST = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  // main instance
  logic          m_in_valid, m_in_ready, m_rnd, m_sat, m_out_valid, m_out_ready, m_ovf;
  logic [W-1:0]  m_a, m_b, m_res;
  logic [TW-1:0] m_tag, m_tag_out;

  // sweep instances share their inputs
  logic          s_in_valid, s_rnd, s_sat, s_out_ready;
  logic [W-1:0]  s_a, s_b;
  logic [TW-1:0] s_tag;
  logic          s1_in_ready, s1_out_valid, s1_ovf;
  logic [W-1:0]  s1_res;
  logic [TW-1:0] s1_tag_out;
  logic          s5_in_ready, s5_out_valid, s5_ovf;
  logic [W-1:0]  s5_res;
  logic [TW-1:0] s5_tag_out;

  fixed_mul_pipe #(.WIDTH(W), .Q_BITS(Q), .STAGES(ST), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .round_en(m_rnd), .sat_en(m_sat), .tag_in(m_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_res),
    .overflow(m_ovf), .tag_out(m_tag_out)
  );

  fixed_mul_pipe #(.WIDTH(W), .Q_BITS(0), .STAGES(1), .TAG_W(TW)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .a(s_a), .b(s_b), .round_en(s_rnd), .sat_en(s_sat), .tag_in(s_tag),
    .out_valid(s1_out_valid), .out_ready(s_out_ready), .result(s1_res),
    .overflow(s1_ovf), .tag_out(s1_tag_out)
  );

  fixed_mul_pipe #(.WIDTH(W), .Q_BITS(0), .STAGES(5), .TAG_W(TW)) dut_s5 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s5_in_ready),
    .a(s_a), .b(s_b), .round_en(s_rnd), .sat_en(s_sat), .tag_in(s_tag),
    .out_valid(s5_out_valid), .out_ready(s_out_ready), .result(s5_res),
    .overflow(s5_ovf), .tag_out(s5_tag_out)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic          ovf;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } sb_t;

  sb_t q_m[$];
  sb_t q_1[$];
  sb_t q_5[$];

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;

  logic [W-1:0]  m_exp_res, s_exp_res;
  logic          m_exp_ovf, s_exp_ovf;
  bit            m_chk_lat;
  bit            m_acc;

  bit            hold_p;
  logic [W-1:0]  hold_res;
  logic          hold_ovf;
  logic [TW-1:0] hold_tag;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Independent reference: 64-bit arithmetic on the real-valued product.
  function automatic logic [W:0] model(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                       input bit rnd, input bit sat, input int q);
    longint p;
    longint r;
    logic [W:0] o;
    p = longint'(x) * longint'(y);
    if (rnd && q > 0) p = p + (64'sd1 <<< (q - 1));
    r = p >>> q;
    o[W] = (r > 32767) || (r < -32768);
    if (o[W] && sat) o[W-1:0] = (r > 0) ? 16'h7FFF : 16'h8000;
    else             o[W-1:0] = r[W-1:0];
    return o;
  endfunction

  task automatic pop_cmp(input string nm, input sb_t e, input logic [W-1:0] res,
                         input logic ovf, input logic [TW-1:0] tg, input int stages);
    chk({nm, "_result"}, 32'(res), 32'(e.res));
    chk({nm, "_overflow"}, 32'(ovf), 32'(e.ovf));
    chk({nm, "_tag"}, 32'(tg), 32'(e.tag));
    if (e.lat) chk({nm, "_latency"}, cyc - e.acc, stages);
  endtask

  // Inputs are driven at the falling edge; handshakes are evaluated 1 time
  // unit later, ahead of the rising edge that performs them.
  task automatic tick();
    sb_t e;
    #1;
    m_acc = 1'b0;
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        chk("hold_valid", 32'(m_out_valid), 1);
        chk("hold_result", 32'(m_res), 32'(hold_res));
        chk("hold_overflow", 32'(m_ovf), 32'(hold_ovf));
        chk("hold_tag", 32'(m_tag_out), 32'(hold_tag));
      end
      if (m_out_valid && !m_out_ready) begin
        stall_cnt++;
        chk("in_ready_stall", 32'(m_in_ready), 0);
      end
      hold_p   = m_out_valid && !m_out_ready;
      hold_res = m_res;
      hold_ovf = m_ovf;
      hold_tag = m_tag_out;

      m_acc = m_in_valid && m_in_ready;
      if (m_acc) begin
        e = '{res: m_exp_res, ovf: m_exp_ovf, tag: m_tag, acc: cyc, lat: m_chk_lat};
        q_m.push_back(e);
      end
      if (s_in_valid && s1_in_ready) begin
        e = '{res: s_exp_res, ovf: s_exp_ovf, tag: s_tag, acc: cyc, lat: 1'b1};
        q_1.push_back(e);
      end
      if (s_in_valid && s5_in_ready) begin
        e = '{res: s_exp_res, ovf: s_exp_ovf, tag: s_tag, acc: cyc, lat: 1'b1};
        q_5.push_back(e);
      end

      if (m_out_valid && m_out_ready) begin
        if (q_m.size() == 0) chk("main_unexpected_beat", 1, 0);
        else begin e = q_m.pop_front(); pop_cmp("main", e, m_res, m_ovf, m_tag_out, ST); end
      end
      if (s1_out_valid && s_out_ready) begin
        if (q_1.size() == 0) chk("s1_unexpected_beat", 1, 0);
        else begin e = q_1.pop_front(); pop_cmp("s1", e, s1_res, s1_ovf, s1_tag_out, 1); end
      end
      if (s5_out_valid && s_out_ready) begin
        if (q_5.size() == 0) chk("s5_unexpected_beat", 1, 0);
        else begin e = q_5.pop_front(); pop_cmp("s5", e, s5_res, s5_ovf, s5_tag_out, 5); end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit rnd, input bit sat,
                      input logic [TW-1:0] tg, input logic [W-1:0] er, input bit eo, input bit lat);
    int guard;
    guard      = 0;
    m_in_valid = 1'b1;
    m_a = x; m_b = y; m_rnd = rnd; m_sat = sat; m_tag = tg;
    m_exp_res  = er;
    m_exp_ovf  = eo;
    m_chk_lat  = lat;
    do begin
      tick();
      guard++;
    end while (!m_acc && guard < 40);
    if (!m_acc) chk("send_timeout", 0, 1);
    m_in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] x, input logic [W-1:0] y, input bit rnd,
                            input bit sat, input logic [TW-1:0] tg, input bit lat);
    logic [W:0] o;
    o = model(x, y, rnd, sat, Q);
    send(x, y, rnd, sat, tg, o[W-1:0], o[W], lat);
  endtask

  task automatic drain();
    int g;
    g = 0;
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
    while ((q_m.size() != 0 || q_1.size() != 0 || q_5.size() != 0) && g < 60) begin
      tick();
      g++;
    end
    chk("drain_empty", q_m.size() + q_1.size() + q_5.size(), 0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, 32'(m_out_valid), 0);
    chk({nm, "_result"}, 32'(m_res), 0);
    chk({nm, "_overflow"}, 32'(m_ovf), 0);
    chk({nm, "_tag_out"}, 32'(m_tag_out), 0);
    chk({nm, "_in_ready"}, 32'(m_in_ready), 1);
  endtask

  initial begin
    logic [W:0]  o;
    logic [31:0] r;
    int k, i;

    rst = 1'b1;
    m_in_valid = 0; m_a = '0; m_b = '0; m_rnd = 0; m_sat = 0; m_tag = '0; m_out_ready = 1;
    s_in_valid = 0; s_a = '0; s_b = '0; s_rnd = 0; s_sat = 0; s_tag = '0; s_out_ready = 1;
    m_exp_res = '0; m_exp_ovf = 0; s_exp_res = '0; s_exp_ovf = 0; m_chk_lat = 0;
    hold_p = 0; hold_res = '0; hold_ovf = 0; hold_tag = '0; m_acc = 0;

    @(negedge clk);
    tick();
    tick();
    chk("in_reset_out_valid", 32'(m_out_valid), 0);
    rst = 1'b0;
    check_idle("post_reset");
    chk("post_reset_s1_out_valid", 32'(s1_out_valid), 0);
    chk("post_reset_s5_out_valid", 32'(s5_out_valid), 0);

    // Basic multiply: 1.5 * 2.0
    send(16'h0180, 16'h0200, 0, 0, 4'h5, 16'h0300, 0, 1);
    drain();

    // Rounding, back to back
    send(16'h0001, 16'h0080, 0, 0, 4'h1, 16'h0000, 0, 1);
    send(16'h0001, 16'h0080, 1, 0, 4'h2, 16'h0001, 0, 1);
    send(16'hFFFF, 16'h0080, 0, 0, 4'h3, 16'hFFFF, 0, 1);
    send(16'hFFFF, 16'h0080, 1, 0, 4'h4, 16'h0000, 0, 1);
    send(16'hFF00, 16'h0180, 0, 0, 4'h5, 16'hFE80, 0, 1);
    send(16'hFF00, 16'h0180, 1, 0, 4'h6, 16'hFE80, 0, 1);
    drain();

    // Overflow and range corners
    send(16'h7F00, 16'h0200, 0, 1, 4'h7, 16'h7FFF, 1, 1);
    send(16'h7F00, 16'h0200, 0, 0, 4'h8, 16'hFE00, 1, 1);
    send(16'h8000, 16'h0200, 0, 1, 4'h9, 16'h8000, 1, 1);
    send(16'h8000, 16'h8000, 0, 1, 4'hA, 16'h7FFF, 1, 1);
    // 0x4040*0x01FE = 32767.5 in Q8: truncation fits, rounding crosses max
    send(16'h4040, 16'h01FE, 0, 1, 4'hB, 16'h7FFF, 0, 1);
    send(16'h4040, 16'h01FE, 1, 1, 4'hC, 16'h7FFF, 1, 1);
    send(16'h4040, 16'h01FE, 1, 0, 4'hD, 16'h8000, 1, 1);
    drain();

    // Backpressure: 8 beats, out_ready low for stream cycles 4..9
    stall_cnt = 0;
    k = 0;
    i = 0;
    while ((k < 8 || i < 12) && i < 60) begin
      m_out_ready = !(i >= 4 && i <= 9);
      if (k < 8) begin
        m_in_valid = 1'b1;
        if (m_tag != 4'(k) || i == 0) begin
          m_a = 16'($urandom()); m_b = 16'($urandom_range(0, 16'h03FF));
          m_rnd = 1'($urandom()); m_sat = 1'($urandom()); m_tag = 4'(k);
          o = model(m_a, m_b, m_rnd, m_sat, Q);
          m_exp_res = o[W-1:0]; m_exp_ovf = o[W]; m_chk_lat = 0;
        end
      end else begin
        m_in_valid = 1'b0;
      end
      tick();
      if (m_acc) k++;
      i++;
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    chk("bp_beats_accepted", k, 8);
    chk("bp_stall_seen", 32'(stall_cnt > 0), 1);
    drain();

    // Reset with three beats in flight
    m_out_ready = 1'b0;
    send_model(16'h0100, 16'h0100, 0, 0, 4'h9, 0);
    send_model(16'h0200, 16'h0100, 0, 0, 4'hA, 0);
    send_model(16'h0300, 16'h0100, 0, 0, 4'hB, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_out_ready = 1'b1;
    q_m.delete();
    check_idle("mid_reset");
    for (int j = 0; j < ST + 2; j++) begin
      tick();
      chk("mid_reset_quiet", 32'(m_out_valid), 0);
    end
    send(16'h0280, 16'h0100, 0, 0, 4'h3, 16'h0280, 0, 1);
    drain();

    // Q0 sweep at depths 1 and 5, back-to-back beats
    for (int j = 0; j < 24; j++) begin
      if (j == 0) begin
        s_a = 16'h8000; s_b = 16'h8000; s_rnd = 1; s_sat = 1;
      end else if (j % 2 == 1) begin
        r = $urandom();
        s_a = {{8{r[7]}}, r[7:0]}; s_b = {{8{r[15]}}, r[15:8]};
        s_rnd = r[16]; s_sat = r[17];
      end else begin
        s_a = 16'($urandom()); s_b = 16'($urandom());
        s_rnd = 1'($urandom()); s_sat = 1'($urandom());
      end
      s_tag = 4'(j);
      o = model(s_a, s_b, s_rnd, s_sat, 0);
      s_exp_res = o[W-1:0];
      s_exp_ovf = o[W];
      s_in_valid = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
